// File: rtl/coincidence_pkg.sv
// Shared types and helpers for the N-channel coincidence engine.
package coincidence_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDOW  = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam int unsigned MAX_CH = 16;
    localparam int unsigned POP_W  = 5;

    // Number of set bits; narrower channel vectors are zero-extended by the caller.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Two-stage level history per channel producing one masked pulse per rising edge.
module edge_detector #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_level,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_edge_c
);

    logic [WIDTH-1:0] r_hit_q;
    logic [WIDTH-1:0] r_hit_prev;

    // History clears to 0 so a level already high at release reads as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_q    <= '0;
            r_hit_prev <= '0;
        end else begin
            r_hit_q    <= i_level;
            r_hit_prev <= r_hit_q;
        end
    end

    assign o_edge_c = r_hit_q & ~r_hit_prev & i_mask;

endmodule

// File: rtl/coincidence_engine.sv
// Multiplicity coincidence detector: collects channel edges inside a window,
// pulses on acceptance, latches the pattern and suspends for a dead-time.
module coincidence_engine
    import coincidence_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned MIN_HITS        = 2,
    parameter int unsigned WINDOW_CYCLES   = 5_000_000,
    parameter int unsigned DEADTIME_CYCLES = 500_000_000,
    parameter int unsigned COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  hit_in,
    input  logic [NUM_CH-1:0]  ch_mask,
    output logic               coincidence_detected,
    output logic [NUM_CH-1:0]  hit_pattern,
    output logic [NUM_CH-1:0]  enable_out,
    output logic               suspended,
    output logic [COUNT_W-1:0] event_count
);

    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned DT_W  = $clog2(DEADTIME_CYCLES + 1);

    state_e            r_state;
    logic [NUM_CH-1:0] r_mask;
    logic [WIN_W-1:0]  r_win_timer;
    logic [DT_W-1:0]   r_dt_timer;

    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_new;
    logic [POP_W-1:0]  w_hits;
    logic              w_accept;

    edge_detector #(
        .WIDTH (NUM_CH)
    ) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_level  (hit_in),
        .i_mask   (ch_mask),
        .o_edge_c (w_edge)
    );

    // Candidate pattern and multiplicity test; edges never count during dead-time.
    always_comb begin
        w_new    = w_edge;
        if (r_state == WINDOW) begin
            w_new = r_mask | w_edge;
        end
        w_hits   = popcount(MAX_CH'(w_new));
        w_accept = (r_state != HOLDOFF) && (w_hits >= POP_W'(MIN_HITS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state              <= IDLE;
            r_mask               <= '0;
            r_win_timer          <= '0;
            r_dt_timer           <= '0;
            coincidence_detected <= 1'b0;
            hit_pattern          <= '0;
            suspended            <= 1'b0;
            event_count          <= '0;
        end else begin
            coincidence_detected <= 1'b0;
            if (w_accept) begin
                coincidence_detected <= 1'b1;
                hit_pattern          <= w_new;
                if (event_count != '1) begin
                    event_count <= event_count + COUNT_W'(1);
                end
                r_state     <= HOLDOFF;
                r_dt_timer  <= '0;
                suspended   <= 1'b1;
                r_mask      <= '0;
                r_win_timer <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (|w_edge) begin
                            r_mask      <= w_edge;
                            r_win_timer <= WIN_W'(1);
                            r_state     <= WINDOW;
                        end
                    end
                    WINDOW: begin
                        // Expiry wins over same-cycle edges: they are dropped, not re-armed.
                        if (r_win_timer == WIN_W'(WINDOW_CYCLES)) begin
                            r_state     <= IDLE;
                            r_mask      <= '0;
                            r_win_timer <= '0;
                        end else begin
                            r_mask      <= w_new;
                            r_win_timer <= r_win_timer + WIN_W'(1);
                        end
                    end
                    HOLDOFF: begin
                        if (r_dt_timer == DT_W'(DEADTIME_CYCLES - 1)) begin
                            r_state    <= IDLE;
                            r_dt_timer <= '0;
                            suspended  <= 1'b0;
                        end else begin
                            r_dt_timer <= r_dt_timer + DT_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign enable_out = ch_mask & ~{NUM_CH{suspended}};

endmodule

// File: tb/tb_coincidence_engine.sv
// Self-checking bench for coincidence_engine: vector table, directed corner
// sequences and randomized traffic against an event-time reference model.
module tb_coincidence_engine;

    localparam int unsigned NCH = 3;
    localparam int unsigned MIN = 2;
    localparam int unsigned WIN = 8;
    localparam int unsigned DT  = 20;
    localparam int unsigned CW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] hit = '0;
    logic [NCH-1:0] mask = 3'b111;
    logic           pulse;
    logic [NCH-1:0] pattern;
    logic [NCH-1:0] en;
    logic           susp;
    logic [CW-1:0]  cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;
    logic pulse_seen = 1'b0;

    coincidence_engine #(
        .NUM_CH          (NCH),
        .MIN_HITS        (MIN),
        .WINDOW_CYCLES   (WIN),
        .DEADTIME_CYCLES (DT),
        .COUNT_W         (CW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .hit_in               (hit),
        .ch_mask              (mask),
        .coincidence_detected (pulse),
        .hit_pattern          (pattern),
        .enable_out           (en),
        .suspended            (susp),
        .event_count          (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks window start time, collected set and remaining dead-time.
    logic [NCH-1:0] m_s1, m_s2, m_set, m_pat;
    logic           m_pulse, m_susp, m_open;
    logic [CW-1:0]  m_cnt;
    int             m_cyc, m_start, m_left;

    always @(posedge clk or negedge rst_n) begin : model
        logic [NCH-1:0] e;
        logic [NCH-1:0] cand;
        logic           acc;
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_set <= '0; m_pat <= '0;
            m_pulse <= 1'b0; m_susp <= 1'b0; m_open <= 1'b0;
            m_cnt <= '0; m_cyc <= 0; m_start <= 0; m_left <= 0;
        end else begin
            e    = m_s1 & ~m_s2 & mask;
            acc  = 1'b0;
            cand = e;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_susp <= 1'b0;
            end else if (m_open) begin
                cand = m_set | e;
                if ($countones(cand) >= MIN) acc = 1'b1;
                else if (m_cyc - m_start >= WIN) m_open <= 1'b0;
                else m_set <= cand;
            end else if (e != 0) begin
                if ($countones(e) >= MIN) acc = 1'b1;
                else begin
                    m_open  <= 1'b1;
                    m_start <= m_cyc;
                    m_set   <= e;
                end
            end
            m_pulse <= acc;
            if (acc) begin
                m_pat  <= cand;
                m_cnt  <= (m_cnt == '1) ? m_cnt : m_cnt + 1'b1;
                m_left <= DT;
                m_susp <= 1'b1;
                m_open <= 1'b0;
            end
            m_s2  <= m_s1;
            m_s1  <= hit;
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model", {pulse, pattern, susp, en, cnt},
                {m_pulse, m_pat, m_susp, mask & ~{NCH{m_susp}}, m_cnt});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        pulse_seen = pulse_seen | pulse;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hit   = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_pulse(input string nm);
        int n = 0;
        while (!pulse && n < 50) begin
            step();
            n++;
        end
        chk(nm, pulse, 1'b1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (susp && n < 60) begin
            step();
            n++;
        end
        chk(nm, susp, 1'b0);
    endtask

    typedef struct packed {
        logic           rst;
        logic [NCH-1:0] hit;
        logic [NCH-1:0] mask;
        logic           p;
        logic [NCH-1:0] pat;
        logic           s;
        logic [NCH-1:0] en;
        logic [CW-1:0]  cnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int n;
        //           rst   hit     mask    p     pat     s     en      cnt
        tbl[0]  = '{1'b1, 3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 3'b111, 4'd0};
        tbl[1]  = '{1'b0, 3'b011, 3'b111, 1'b0, 3'b000, 1'b0, 3'b111, 4'd0};
        tbl[2]  = '{1'b0, 3'b011, 3'b111, 1'b1, 3'b011, 1'b1, 3'b000, 4'd1};
        tbl[3]  = '{1'b0, 3'b011, 3'b111, 1'b0, 3'b011, 1'b1, 3'b000, 4'd1};
        tbl[4]  = '{1'b1, 3'b000, 3'b110, 1'b0, 3'b000, 1'b0, 3'b110, 4'd0};
        tbl[5]  = '{1'b0, 3'b011, 3'b110, 1'b0, 3'b000, 1'b0, 3'b110, 4'd0};
        tbl[6]  = '{1'b0, 3'b011, 3'b110, 1'b0, 3'b000, 1'b0, 3'b110, 4'd0};
        tbl[7]  = '{1'b0, 3'b011, 3'b110, 1'b0, 3'b000, 1'b0, 3'b110, 4'd0};
        tbl[8]  = '{1'b0, 3'b111, 3'b110, 1'b0, 3'b000, 1'b0, 3'b110, 4'd0};
        tbl[9]  = '{1'b0, 3'b111, 3'b110, 1'b1, 3'b110, 1'b1, 3'b000, 4'd1};
        tbl[10] = '{1'b0, 3'b111, 3'b110, 1'b0, 3'b110, 1'b1, 3'b000, 4'd1};

        step();
        do_reset();
        chk_en = 1'b1;

        // Simultaneous hits and masked-channel vectors.
        for (int i = 0; i < 11; i++) begin
            rst_n = ~tbl[i].rst;
            hit   = tbl[i].hit;
            mask  = tbl[i].mask;
            step();
            chk($sformatf("vec%0d", i), {pulse, pattern, susp, en, cnt},
                {tbl[i].p, tbl[i].pat, tbl[i].s, tbl[i].en, tbl[i].cnt});
        end
        rst_n = 1'b1;
        mask  = 3'b111;

        // Two hits five cycles apart, then full dead-time length.
        do_reset();
        hit = 3'b001;
        steps(5);
        hit = 3'b101;
        steps(2);
        chk("t1_pulse", pulse, 1'b1);
        chk("t1_pattern", pattern, 3'b101);
        chk("t1_count", cnt, 4'd1);
        chk("t1_enable", en, 3'b000);
        n = 0;
        while (susp && n < 40) begin
            n++;
            step();
        end
        chk("t1_deadtime_len", n, DT);

        // Window expiry, then a second window opened by the late hit.
        do_reset();
        hit = 3'b001;
        pulse_seen = 1'b0;
        steps(9);
        hit = 3'b011;
        steps(3);
        hit = 3'b111;
        chk("t2_no_early_pulse", pulse_seen, 1'b0);
        steps(2);
        chk("t2_pulse", pulse, 1'b1);
        chk("t2_pattern", pattern, 3'b110);

        // Edges during dead-time, inputs held high across exit.
        do_reset();
        hit = 3'b001;
        step();
        hit = 3'b011;
        wait_pulse("t5_accept_timeout");
        pulse_seen = 1'b0;
        steps(2);
        hit = 3'b000;
        steps(2);
        hit = 3'b111;
        wait_idle("t5_idle_timeout");
        steps(10);
        chk("t5_no_retrigger", pulse_seen, 1'b0);
        chk("t5_count_kept", cnt, 4'd1);

        // Counter saturation over 17 accepted coincidences.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            hit = 3'b000;
            steps(2);
            hit = 3'b011;
            wait_pulse("t5_sat_pulse_timeout");
            if (k == 14) chk("t5_count_15", cnt, 4'd15);
            wait_idle("t5_sat_idle_timeout");
        end
        chk("t5_saturated", cnt, 4'd15);

        // Asynchronous reset mid-window.
        do_reset();
        hit = 3'b001;
        steps(3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6a_reset_outs", {pulse, pattern, susp, en, cnt}, {1'b0, 3'b000, 1'b0, 3'b111, 4'd0});
        hit = 3'b000;
        step();
        rst_n = 1'b1;
        hit = 3'b010;
        pulse_seen = 1'b0;
        steps(15);
        chk("t6a_single_no_pulse", pulse_seen, 1'b0);

        // Asynchronous reset mid-dead-time.
        do_reset();
        hit = 3'b011;
        wait_pulse("t6b_accept_timeout");
        steps(3);
        chk("t6b_suspended", susp, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6b_reset_outs", {pulse, pattern, susp, en, cnt}, {1'b0, 3'b000, 1'b0, 3'b111, 4'd0});
        hit = 3'b000;
        step();
        rst_n = 1'b1;
        hit = 3'b010;
        pulse_seen = 1'b0;
        steps(15);
        chk("t6b_single_no_pulse", pulse_seen, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(7) == 0) hit[c] = ~hit[c];
            end
            if ($urandom_range(31) == 0) mask = 3'($urandom_range(7));
        end
        step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coincidence_engine.md
Name: coincidence_engine

Overview:
- N-channel generalisation of the two-button coincidence/suspension pair.
- Detects when at least MIN_HITS of NUM_CH enabled channels produce rising edges within a programmable window.
- Then issues a one-cycle coincidence pulse, latches the hit pattern and enters a dead-time during which all channel enables drop.
- Sits between the debounced/synchronised detector inputs and the per-channel lifetime counters.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- MIN_HITS, 2, required multiplicity (1..NUM_CH).
- WINDOW_CYCLES, 5_000_000, coincidence window length in clk cycles (>=1).
- DEADTIME_CYCLES, 500_000_000, suspension length in clk cycles after a coincidence (>=1).
- COUNT_W, 16, width of the saturating event counter.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- hit_in  in  NUM_CH  debounced, already-synchronised channel levels.
- ch_mask  in  NUM_CH  1 = channel participates; masked channels never contribute hits.
- coincidence_detected  out  1  one-cycle pulse per accepted coincidence.
- hit_pattern  out  NUM_CH  channels hit in the accepted window; held until the next coincidence.
- enable_out  out  NUM_CH  per-channel counter enable = ch_mask when not suspended, else 0.
- suspended  out  1  high throughout dead-time.
- event_count  out  COUNT_W  accepted coincidences, saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; window/dead-time timers and accumulated mask = 0.
  - Internal input-history registers = 0, so a channel already high at release counts as an edge on the next rising clock edge.
  - Outputs: coincidence_detected=0, hit_pattern=0, suspended=0, event_count=0.
  - enable_out combinational: equals ch_mask while rst_n is low and after release.
  - Reset mid-window or mid-dead-time abandons the operation without a pulse.
- Edge detection:
  - hit_q registers hit_in; hit_prev registers hit_q.
  - edge = hit_q & ~hit_prev & ch_mask.
  - One pulse per rising edge regardless of how long the input stays high.
- IDLE:
  - edge == 0: stay.
  - popcount(edge) >= MIN_HITS: accept immediately. This covers simultaneous hits, and MIN_HITS=1 always accepts here.
  - Otherwise: mask <= edge, timer <= 1, go WINDOW.
- WINDOW:
  - new = mask | edge.
  - popcount(new) >= MIN_HITS: accept.
  - Else if timer == WINDOW_CYCLES: drop to IDLE with mask cleared. Edges on that same cycle are discarded and do not start a new window.
  - Else mask <= new, timer <= timer+1.
  - A repeated edge on an already-hit channel does not add to the count.
- Accept, registered on the same clock edge:
  - coincidence_detected=1 for exactly one cycle.
  - hit_pattern <= qualifying mask.
  - event_count +1, saturating.
  - Go HOLDOFF with dead-time counter = 0; suspended=1 from the next cycle.
- Latency: input high before clk edge k → edge visible in cycle k..k+1 → pulse high from edge k+1 to k+2.
- HOLDOFF:
  - Edges ignored.
  - Counter increments each cycle; after DEADTIME_CYCLES cycles, return to IDLE with suspended=0.
  - Inputs still high at exit do not retrigger, because edge detection continues running during HOLDOFF.
- enable_out = ch_mask & ~{NUM_CH{suspended}}.
- A ch_mask change mid-window affects only future edges; the accumulated mask is kept.
- Timer widths are $clog2(param+1); no wrap is possible.

Decomposition:
- Package coincidence_pkg:
  - state enum {IDLE, WINDOW, HOLDOFF}.
  - popcount function.
  - Width helper constants.
- Sub-module edge_detector (parametrised width), holding hit_q/hit_prev and the masked edge output.
- FSM, timers and counter stay in coincidence_engine.

Test Plan (NUM_CH=3, MIN_HITS=2, WINDOW_CYCLES=8, DEADTIME_CYCLES=20, COUNT_W=4 unless stated):
1. ch0 rises at cycle 0, ch2 at cycle 5 → one pulse, hit_pattern=3'b101, event_count=1, suspended high for 20 cycles, enable_out=0 during dead-time.
2. ch0 rises at cycle 0, ch1 at cycle 9 → no pulse; the window expires. ch1 opens a new window; ch2 at cycle 12 → pulse, hit_pattern=3'b110.
3. ch0 and ch1 rise on the same edge → pulse exactly 2 cycles later, hit_pattern=3'b011, WINDOW state never entered.
4. ch_mask=3'b110, ch0 and ch1 rise together → no pulse. ch2 rising 3 cycles later → pulse, hit_pattern=3'b110.
5. Edges on all channels during HOLDOFF with inputs held high past exit → no pulse; event_count unchanged. 17 back-to-back accepted coincidences → event_count saturates at 15.
6. rst_n pulsed low mid-WINDOW (ch0 hit) and again mid-HOLDOFF → all outputs return to reset values asynchronously. After release, ch1 alone produces no pulse.
